// File: rtl/fp_classify_pipe.sv
// fp_classify_pipe: per-channel FP operand classifier behind a 2-entry skid buffer, with sticky flags.
// Define FPCLASS_DAZ_EN to treat subnormals as zero (class 0, fraction cleared).
module fp_classify_pipe #(
   parameter int EXPW = 8,
   parameter int SIGW = 23,
   parameter int NCH  = 2,
   parameter int OPW  = 1 + EXPW + SIGW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NCH*OPW-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NCH*OPW-1:0]   out_data,
   output logic [NCH*3-1:0]     out_class,
   output logic                 out_spec,
   output logic                 out_invalid,
   input  logic                 flag_clr,
   output logic                 sticky_inv,
   output logic                 sticky_spec
);
   localparam int PW = NCH*OPW + NCH*3 + 2;
`ifdef FPCLASS_DAZ_EN
   localparam logic [2:0] SUB_CLS = 3'd0;
`else
   localparam logic [2:0] SUB_CLS = 3'd1;
`endif
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t r_state, w_next;
   logic [PW-1:0] r_out, r_skid, w_pay;
   logic [NCH*OPW-1:0] w_data;
   logic [NCH*3-1:0] w_class;
   logic [NCH-1:0] w_pinf, w_ninf, w_snan, w_spec;
   logic w_xfer, w_inv, w_spec_any, w_ld_out, w_ld_skid, w_sel_skid, r_in_ready;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [EXPW-1:0] w_e;
      logic [SIGW-1:0] w_f;
      logic            w_s;
      logic [2:0]      w_c;
      assign w_s = in_data[k*OPW+OPW-1];
      assign w_e = in_data[k*OPW+SIGW +: EXPW];
      assign w_f = in_data[k*OPW +: SIGW];
      assign w_c = (w_e == '0) ? ((w_f == '0) ? 3'd0 : SUB_CLS) :
                   (&w_e) ? ((w_f == '0) ? 3'd3 : (w_f[SIGW-1] ? 3'd4 : 3'd5)) : 3'd2;
      assign w_class[k*3 +: 3] = w_c;
      assign w_spec[k] = (w_c >= 3'd3);
      assign w_snan[k] = (w_c == 3'd5);
      assign w_pinf[k] = (w_c == 3'd3) & !w_s;
      assign w_ninf[k] = (w_c == 3'd3) & w_s;
`ifdef FPCLASS_DAZ_EN
      assign w_data[k*OPW +: OPW] = (w_e == '0) ? {w_s, w_e, {SIGW{1'b0}}} : in_data[k*OPW +: OPW];
`else
      assign w_data[k*OPW +: OPW] = in_data[k*OPW +: OPW];
`endif
   end

   assign w_spec_any = |w_spec;
   assign w_inv      = (|w_snan) | ((|w_pinf) & (|w_ninf));
   assign w_pay      = {w_inv, w_spec_any, w_class, w_data};
   assign w_xfer     = in_valid & in_ready;
   assign in_ready   = r_in_ready;
   assign out_valid  = (r_state != EMPTY);
   assign {out_invalid, out_spec, out_class, out_data} = r_out;

   always_comb begin
      w_next = r_state;
      w_ld_out = 1'b0;
      w_ld_skid = 1'b0;
      w_sel_skid = 1'b0;
      case (r_state)
         EMPTY: if (w_xfer) begin
            w_next = ONE;
            w_ld_out = 1'b1;
         end
         ONE: if (w_xfer & out_ready) w_ld_out = 1'b1;
            else if (w_xfer) begin
               w_next = FULL;
               w_ld_skid = 1'b1;
            end else if (out_ready) w_next = EMPTY;
         FULL: if (out_ready) begin
            w_next = ONE;
            w_ld_out = 1'b1;
            w_sel_skid = 1'b1;
         end
         default: w_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
         r_in_ready <= 1'b1;
         r_out <= '0;
         r_skid <= '0;
         sticky_inv <= 1'b0;
         sticky_spec <= 1'b0;
      end else begin
         r_state <= w_next;
         r_in_ready <= (w_next != FULL);
         if (w_ld_out) r_out <= w_sel_skid ? r_skid : w_pay;
         if (w_ld_skid) r_skid <= w_pay;
         // set beats clear when both happen on the same edge
         sticky_inv <= (w_xfer & w_inv) | (sticky_inv & !flag_clr);
         sticky_spec <= (w_xfer & w_spec_any) | (sticky_spec & !flag_clr);
      end
   end
endmodule

// File: tb/tb_fp_classify_pipe.sv
// tb_fp_classify_pipe: directed checks of classification, backpressure, stickies, reset and a half-precision instance.
module tb_fp_classify_pipe;
   logic clk = 1'b0, reset = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1, flag_clr = 1'b0;
   logic [63:0] in_data = '0;
   logic in_ready, out_valid, out_spec, out_invalid, sticky_inv, sticky_spec;
   logic [63:0] out_data;
   logic [5:0] out_class;
   logic h_valid = 1'b0;
   logic [63:0] h_data = '0;
   logic h_ready, h_ovalid, h_spec, h_invalid, h_sinv, h_sspec;
   logic [63:0] h_odata;
   logic [11:0] h_class;
   int n_checks = 0, n_fail = 0;
   logic [2:0] sub_cls;
   logic [31:0] sub_data;

   always #5 clk = ~clk;

   fp_classify_pipe dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
      .out_spec(out_spec), .out_invalid(out_invalid), .flag_clr(flag_clr),
      .sticky_inv(sticky_inv), .sticky_spec(sticky_spec));

   fp_classify_pipe #(.EXPW(5), .SIGW(10), .NCH(4)) dut_h (
      .clk(clk), .reset(reset), .in_valid(h_valid), .in_ready(h_ready), .in_data(h_data),
      .out_valid(h_ovalid), .out_ready(1'b1), .out_data(h_odata), .out_class(h_class),
      .out_spec(h_spec), .out_invalid(h_invalid), .flag_clr(1'b0),
      .sticky_inv(h_sinv), .sticky_spec(h_sspec));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ch0, input logic [31:0] ch1);
      in_valid = 1'b1;
      in_data = {ch1, ch0};
      step();
      in_valid = 1'b0;
   endtask

   initial begin
`ifdef FPCLASS_DAZ_EN
      sub_cls = 3'd0;
      sub_data = 32'h0;
`else
      sub_cls = 3'd1;
      sub_data = 32'h1;
`endif
      repeat (2) step();
      reset = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
      check("rst_data", out_data, 0);
      check("rst_sticky", {sticky_inv, sticky_spec}, 0);

      send(32'h7F800000, 32'hFF800000);
      check("inf_valid", out_valid, 1);
      check("inf_class", out_class, {3'd3, 3'd3});
      check("inf_flags", {out_spec, out_invalid}, 2'b11);
      check("inf_sticky", {sticky_inv, sticky_spec}, 2'b11);

      send(32'h7FC00000, 32'h7F800001);
      check("nan_class", out_class, {3'd5, 3'd4});
      check("nan_flags", {out_spec, out_invalid}, 2'b11);
      check("nan_data", out_data, 64'h7F800001_7FC00000);

      send(32'h00000001, 32'h3F800000);
      check("sub_class", out_class, {3'd2, sub_cls});
      check("sub_flags", {out_spec, out_invalid}, 2'b00);
      check("sub_data", out_data, {32'h3F800000, sub_data});

      send(32'h80000000, 32'h7F800000);
      check("pinf_class", out_class, {3'd3, 3'd0});
      check("pinf_flags", {out_spec, out_invalid}, 2'b10);

      h_valid = 1'b1;
      h_data = {16'h0000, 16'h7D00, 16'h7E00, 16'h7C00};
      step();
      h_valid = 1'b0;
      check("empty_after", out_valid, 0);
      check("h_class", h_class, {3'd0, 3'd5, 3'd4, 3'd3});
      check("h_flags", {h_spec, h_invalid, h_sinv}, 3'b111);

      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      check("clr_alone", {sticky_inv, sticky_spec}, 0);
      flag_clr = 1'b1;
      send(32'h7F800001, 32'h3F800000);
      flag_clr = 1'b0;
      check("clr_set_wins", sticky_inv, 1);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      check("clr_after", sticky_inv, 0);

      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = {32'h0, 32'hA};
      step();
      check("bp_a_ready", in_ready, 1);
      in_data = {32'h0, 32'hB};
      step();
      check("bp_full_ready", in_ready, 0);
      check("bp_hold_a", out_data, {32'h0, 32'hA});
      in_data = {32'h0, 32'hC};
      step();
      check("bp_c_held", in_ready, 0);
      check("bp_still_a", out_data, {32'h0, 32'hA});
      out_ready = 1'b1;
      step();
      check("bp_out_b", {out_valid, out_data}, {1'b1, 32'h0, 32'hB});
      check("bp_ready_up", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("bp_out_c", {out_valid, out_data}, {1'b1, 32'h0, 32'hC});
      step();
      check("bp_drained", out_valid, 0);

      out_ready = 1'b0;
      send(32'h7F800000, 32'hFF800000);
      send(32'h7F800001, 32'h0);
      check("pre_rst_full", in_ready, 0);
      reset = 1'b1;
      in_valid = 1'b1;
      in_data = {32'h0, 32'h7F800001};
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      check("mrst_vr", {out_valid, in_ready}, 2'b01);
      check("mrst_out", {out_data, out_class, out_spec, out_invalid}, 0);
      check("mrst_sticky", {sticky_inv, sticky_spec}, 0);
      out_ready = 1'b1;
      send(32'h40000000, 32'h0);
      check("post_rst_beat", {out_valid, out_data}, {1'b1, 32'h0, 32'h40000000});
      check("post_rst_class", out_class, {3'd0, 3'd2});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
